// File: rtl/bootrom_copier.sv
// Copies LEN_WORDS 16-bit words from a 1-cycle-latency boot ROM into RAM,
// one word per READ/WAIT/WRITE sequence, keeping a wrapping 16-bit checksum.
module bootrom_copier #(
    parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
    parameter logic [31:0] DST_BASE  = 32'h0010_0000,
    parameter int unsigned LEN_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum,
    output logic [31:0] rom_addr,
    output logic        rom_enable,
    input  logic [15:0] rom_data,
    input  logic        rom_berr,
    output logic [31:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        ram_we,
    input  logic        ram_ready
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, WRITE, DONE, ERROR
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(LEN_WORDS - 1);

    state_t      state_q;
    logic [15:0] idx_q;
    logic        busy_q, done_q, error_q;
    logic [15:0] csum_q;
    logic [31:0] rom_addr_q, ram_addr_q;
    logic        rom_en_q, ram_we_q;
    logic [15:0] ram_data_q;

    logic [15:0] idx_inc_d;
    logic        last_d;

    // Byte address of word i; bit 0 is forced low so an odd base cannot leak through.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] i);
        logic [31:0] sum;
        sum = base + {15'd0, i, 1'b0};
        return {sum[31:1], 1'b0};
    endfunction

    function automatic logic [15:0] wrap_add16(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    assign idx_inc_d = idx_q + 16'd1;
    assign last_d    = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            csum_q     <= 16'd0;
            rom_addr_q <= SRC_BASE;
            rom_en_q   <= 1'b0;
            ram_addr_q <= DST_BASE;
            ram_data_q <= 16'd0;
            ram_we_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        idx_q      <= 16'd0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        csum_q     <= 16'd0;
                        busy_q     <= 1'b1;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= word_addr(SRC_BASE, 16'd0);
                        state_q    <= READ;
                    end
                end
                READ: begin
                    rom_en_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // ROM data and berr arrive one cycle after the enable pulse.
                    if (rom_berr) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERROR;
                    end else begin
                        ram_data_q <= rom_data;
                        ram_addr_q <= word_addr(DST_BASE, idx_q);
                        ram_we_q   <= 1'b1;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    if (ram_ready) begin
                        csum_q   <= wrap_add16(csum_q, ram_data_q);
                        ram_we_q <= 1'b0;
                        if (last_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            idx_q      <= idx_inc_d;
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= word_addr(SRC_BASE, idx_inc_d);
                            state_q    <= READ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign checksum   = csum_q;
    assign rom_addr   = rom_addr_q;
    assign rom_enable = rom_en_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_bootrom_copier.sv
// Directed bench for bootrom_copier with a 4-word image, a 1-cycle ROM model
// and a RAM write monitor; expectations are hand-computed constants.
module tb_bootrom_copier;

    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0010_0000;

    logic        clk;
    logic        reset_n, start;
    logic        busy, done, error;
    logic [15:0] checksum;
    logic [31:0] rom_addr, ram_addr;
    logic        rom_enable, rom_berr, ram_we, ram_ready;
    logic [15:0] rom_data, ram_data;

    bootrom_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .LEN_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .error(error), .checksum(checksum), .rom_addr(rom_addr),
        .rom_enable(rom_enable), .rom_data(rom_data), .rom_berr(rom_berr),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_ready(ram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [4];
    logic [2:0]  berr_idx;

    // ROM responder: data and berr valid the cycle after rom_enable.
    always @(posedge clk) begin
        if (rom_enable) begin
            rom_data <= mem[rom_addr[2:1]];
            rom_berr <= (rom_addr[3:1] == berr_idx);
        end else begin
            rom_data <= 16'hDEAD;
            rom_berr <= 1'b0;
        end
    end

    int          wr_n, rd_n;
    logic [31:0] wr_addr [8];
    logic [15:0] wr_data [8];
    logic        mon_clr;

    always @(posedge clk) begin
        if (mon_clr) begin
            wr_n <= 0;
            rd_n <= 0;
        end else begin
            if (ram_we && ram_ready) begin
                if (wr_n < 8) begin
                    wr_addr[wr_n[2:0]] <= ram_addr;
                    wr_data[wr_n[2:0]] <= ram_data;
                end
                wr_n <= wr_n + 1;
            end
            if (rom_enable) rd_n <= rd_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(done || error); i++) tick();
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_copy(input string t, input bit poke_mid);
        int n;
        clear_mon();
        pulse_start();
        chk({t, "_busy_go"}, 32'(busy), 1);
        chk({t, "_done_clr"}, 32'(done), 0);
        chk({t, "_csum_clr"}, 32'(checksum), 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            start = (poke_mid && n == 6);
            tick();
        end
        start = 1'b0;
        chk({t, "_busy_cycles"}, n, 12);
        chk({t, "_done"}, 32'(done), 1);
        chk({t, "_error"}, 32'(error), 0);
        chk({t, "_csum"}, 32'(checksum), 32'h0000_AAAA);
        chk({t, "_nwrites"}, wr_n, 4);
        chk({t, "_nreads"}, rd_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk({t, "_waddr"}, wr_addr[i[2:0]], DST + 32'(2 * i));
            chk({t, "_wdata"}, 32'(wr_data[i[2:0]]), 32'(mem[i[1:0]]));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        ram_ready = 1'b1;
        mon_clr   = 1'b1;
        berr_idx  = 3'd7;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_csum", 32'(checksum), 0);
        chk("rst_rom_en", 32'(rom_enable), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_rom_addr", rom_addr, SRC);
        chk("rst_ram_addr", ram_addr, DST);
        chk("rst_ram_data", 32'(ram_data), 0);
        reset_n = 1'b1;
        mon_clr = 1'b0;
        tick();

        // Basic copy, then restart from DONE with a start poke mid-copy.
        do_copy("basic", 1'b0);
        do_copy("restart", 1'b1);

        // Backpressure: ram_ready low for 5 WRITE cycles on word 2.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 50 && !(rom_enable && rom_addr == SRC + 32'd4); i++) tick();
        chk("bp_read2", rom_addr, SRC + 32'd4);
        ram_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) ram_ready = 1'b1;
            chk("bp_we_hold", 32'(ram_we), 1);
            chk("bp_addr_hold", ram_addr, DST + 32'd4);
            chk("bp_data_hold", 32'(ram_data), 32'h3333);
            tick();
        end
        wait_end(50);
        chk("bp_done", 32'(done), 1);
        chk("bp_csum", 32'(checksum), 32'h0000_AAAA);
        chk("bp_nwrites", wr_n, 4);
        chk("bp_waddr2", wr_addr[2], DST + 32'd4);
        chk("bp_waddr3", wr_addr[3], DST + 32'd6);
        chk("bp_wdata2", 32'(wr_data[2]), 32'h3333);

        // Bus error on word 2.
        berr_idx = 3'd2;
        clear_mon();
        pulse_start();
        wait_end(100);
        chk("berr_error", 32'(error), 1);
        chk("berr_done", 32'(done), 0);
        chk("berr_busy", 32'(busy), 0);
        chk("berr_csum", 32'(checksum), 32'h3333);
        chk("berr_nwrites", wr_n, 2);
        chk("berr_nreads", rd_n, 3);
        repeat (5) tick();
        chk("berr_nreads_after", rd_n, 3);
        chk("berr_rom_en", 32'(rom_enable), 0);
        chk("berr_rom_addr", rom_addr, SRC + 32'd4);
        berr_idx = 3'd7;

        // Checksum wrap, started from ERROR.
        mem[0] = 16'hFFFF; mem[1] = 16'h0002; mem[2] = 16'h0000; mem[3] = 16'h0000;
        clear_mon();
        pulse_start();
        chk("wrap_err_clr", 32'(error), 0);
        chk("wrap_busy", 32'(busy), 1);
        wait_end(100);
        chk("wrap_done", 32'(done), 1);
        chk("wrap_csum", 32'(checksum), 32'h0001);

        // Reset while word 1 is stalled in WRITE.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 50 && !(rom_enable && rom_addr == SRC + 32'd2); i++) tick();
        ram_ready = 1'b0;
        for (int i = 0; i < 10 && !ram_we; i++) tick();
        chk("rstmid_we_pre", 32'(ram_we), 1);
        chk("rstmid_addr_pre", ram_addr, DST + 32'd2);
        chk("rstmid_csum_pre", 32'(checksum), 32'hFFFF);
        reset_n = 1'b0;
        tick();
        chk("rstmid_we", 32'(ram_we), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_csum", 32'(checksum), 0);
        chk("rstmid_rom_addr", rom_addr, SRC);
        ram_ready = 1'b1;
        reset_n   = 1'b1;
        repeat (4) tick();
        chk("rstmid_nwrites", wr_n, 1);
        chk("rstmid_we_after", 32'(ram_we), 0);
        chk("rstmid_busy_after", 32'(busy), 0);
        chk("rstmid_done_after", 32'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bootrom_copier.md
Name: bootrom_copier

Overview:
- Bus initiator that reads words from a boot ROM responder and writes them into a RAM responder.
- It copies the ROM image to RAM at reset-exit so the CPU can run from writable memory, and it keeps a running 16-bit checksum of the copy.
- It sits between the ROM (synchronous read, 1-cycle latency, returns a berr flag) and the RAM write port (address/data/strobe with a ready handshake).
- It drives the ROM address and enable that the CPU would otherwise drive.

Parameters:
- SRC_BASE, 32'h0000_0000, byte address of the first ROM word (must be even).
- DST_BASE, 32'h0010_0000, byte address of the first RAM word (must be even).
- LEN_WORDS, 1024, number of 16-bit words to copy (1..65535).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  a rising level while idle (or in DONE/ERROR) begins a copy.
- busy  out  1  high from the cycle after start is accepted until the cycle DONE/ERROR is entered.
- done  out  1  sticky; set when the copy completes; cleared when a new start is accepted.
- error  out  1  sticky; set on ROM berr; cleared when a new start is accepted.
- checksum  out  16  mod-2^16 sum of all words written so far this run.
- rom_addr  out  32  byte address to the ROM.
- rom_enable  out  1  ROM read enable.
- rom_data  in  16  ROM read data, valid the cycle after rom_enable=1.
- rom_berr  in  1  bus error, sampled together with rom_data.
- ram_addr  out  32  byte address to the RAM.
- ram_data  out  16  write data to the RAM.
- ram_we  out  1  write strobe; held until ram_ready.
- ram_ready  in  1  RAM accepted the write this cycle (when ram_we=1).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, error=0, checksum=0, rom_enable=0, ram_we=0; rom_addr=SRC_BASE, ram_addr=DST_BASE, ram_data=0. Reset mid-copy aborts immediately; no further strobes are issued.
- Internal word counter idx, 16 bits.
- IDLE/DONE/ERROR:
  - start=1 → load idx=0, clear done, error and checksum, go to READ.
  - start is ignored in every other state.
- READ (1 cycle): rom_enable=1, rom_addr=SRC_BASE+2*idx → WAIT.
- WAIT (1 cycle): rom_enable=0; sample rom_data and rom_berr.
  - rom_berr=1 → ERROR; error=1; no write for this word; checksum unchanged.
  - rom_berr=0 → latch ram_data=rom_data, ram_addr=DST_BASE+2*idx → WRITE.
- WRITE:
  - Hold ram_we=1 with stable ram_addr and ram_data until ram_ready=1.
  - In the ready cycle: checksum += ram_data (wraps mod 2^16).
  - If idx==LEN_WORDS-1 → DONE with done=1; else idx+=1 → READ.
  - ram_we drops the cycle after ready.
- busy is high in READ, WAIT and WRITE only.
- Address arithmetic is 32-bit and wraps modulo 2^32. Bits [0] of rom_addr and ram_addr are always 0.
- rom_data and rom_berr are ignored outside WAIT.
- ram_ready is ignored when ram_we=0.
- Throughput is 3 cycles per word when ram_ready is held high, so a full copy takes 3*LEN_WORDS cycles from the first READ to the DONE entry.
- start held high across DONE restarts the copy on the next cycle (the level is sampled in DONE).
- The ROM address is never advanced past a berr. error and done are never both 1.

Test Plan:
- Basic copy: LEN_WORDS=4, ROM words 1111/2222/3333/4444, ram_ready tied high → writes to DST_BASE+0, +2, +4, +6 with matching data; done=1 after 12 cycles of busy; checksum=AAAA.
- Backpressure: ram_ready low for 5 cycles on word 2 → ram_we, ram_addr and ram_data stay stable for 6 cycles; exactly one write per address; final checksum unchanged.
- Bus error: rom_berr=1 on word index 2 → two writes only; error=1, done=0, busy=0; checksum=sum of the first two words; no further rom_enable.
- Checksum wrap: words FFFF and 0002 → checksum=0001.
- Restart and ignore: start asserted mid-copy → no effect. start after DONE → done and checksum cleared the next cycle; second copy is identical to the first.
- Reset mid-copy: reset_n low during WRITE → next cycle ram_we=0, busy=0, checksum=0, rom_addr=SRC_BASE; no write is completed after reset.
